// File: rtl/uart_rx_ctrl.sv
`timescale 1ns/1ps
// UART receive-path controller: 16x oversampling tick, rx synchroniser, frame sequencer, valid/ready output.
// Optional even-parity stage is enabled by defining UART_RX_CTRL_PARITY_EN.
module uart_rx_ctrl #(
  parameter int pSYS_CLK_FREQ = 50_000_000,
  parameter int pBAUD_RATE    = 115_200,
  parameter int DATA_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int OVS_DIV = pSYS_CLK_FREQ / (pBAUD_RATE * 16);
  localparam int DIV_W   = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OVS_DIV - 1);

  if (OVS_DIV < 1) begin : g_bad_ovs_div
    $error("uart_rx_ctrl: clock too slow for 16x oversampling of the baud rate");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_rx_ctrl: DATA_BITS must be within 5..8");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_CTRL_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state, state_nxt;
  logic                 sync1, rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick, mid_hit, end_hit;
  logic [3:0]           tcnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shift;
  logic                 stop_sample, par_ok, accept;

  assign tick        = (div_cnt == DIV_LAST);
  assign mid_hit     = tick && (tcnt == 4'd7);
  assign end_hit     = tick && (tcnt == 4'd15);
  assign stop_sample = (state == STOP) && end_hit;
  assign accept      = stop_sample && rx_s && par_ok;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (mid_hit) state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_CTRL_PARITY_EN
      DATA:      if (end_hit && idx == 3'(DATA_BITS - 1)) state_nxt = PARITY;
      PARITY:    if (end_hit) state_nxt = STOP;
`else
      DATA:      if (end_hit && idx == 3'(DATA_BITS - 1)) state_nxt = STOP;
`endif
      // A low stop bit may be a break; wait for the line to recover before re-arming.
      STOP:      if (end_hit) state_nxt = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1       <= 1'b1;
      rx_s        <= 1'b1;
      div_cnt     <= '0;
      tcnt        <= '0;
      idx         <= '0;
      shift       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;

      // Restarting the divider on start detection centres the samples in each bit.
      if ((state == IDLE && state_nxt == START) || tick) div_cnt <= '0;
      else                                               div_cnt <= div_cnt + DIV_W'(1);

      if (state_nxt != state) tcnt <= '0;
      else if (tick)          tcnt <= tcnt + 4'd1;

      if (state == START && state_nxt == DATA) begin
        idx   <= '0;
        shift <= '0;
      end else if (state == DATA && end_hit) begin
        idx   <= idx + 3'd1;
        shift <= {rx_s, shift[DATA_BITS-1:1]};
      end

      frame_err   <= stop_sample && !rx_s;
      overrun_err <= accept && data_valid && !data_ready;

      if (accept && (!data_valid || data_ready)) begin
        data_out   <= shift;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_CTRL_PARITY_EN
  logic par_bit;

  assign par_ok = ~^{shift, par_bit};

  always_ff @(posedge clk) begin
    if (!rst) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == PARITY && end_hit) par_bit <= rx_s;
      // A framing error outranks a parity error on the same frame.
      parity_err <= stop_sample && rx_s && !par_ok;
    end
  end
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized frames scored against
// a frame-level outcome model. Parity scenarios run when UART_RX_CTRL_PARITY_EN is defined.
module tb_uart_rx_ctrl;

  localparam int SYS_CLK   = 1_600_000;
  localparam int BAUD      = 10_000;
  localparam int DATA_BITS = 8;
  localparam int OVS       = SYS_CLK / (BAUD * 16);
  localparam int BIT       = OVS * 16;
  localparam int GAP       = 40;
`ifdef UART_RX_CTRL_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // rx fall -> START entry (3), then 8 ticks to mid start, 16 per data/parity bit, 16 to the stop sample.
  localparam int LAT = 3 + (8 + 16 * DATA_BITS + 16 * PBITS + 16) * OVS;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rx;
  logic                 data_ready;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 parity_err;
  logic                 busy;

  uart_rx_ctrl #(
    .pSYS_CLK_FREQ(SYS_CLK),
    .pBAUD_RATE   (BAUD),
    .DATA_BITS    (DATA_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: counts pulses, records consumed bytes, checks hold while stalled.
  logic [7:0] got_q[$];
  int   n_valid, n_frame, n_over, n_par, first_valid;
  logic prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (prev_valid && !prev_ready && rst) begin
      check("hold_valid", 32'(data_valid), 32'd1);
      check("hold_data", 32'(data_out), 32'(prev_data));
    end
    if (data_valid && data_ready) got_q.push_back(data_out);
    if (data_valid) n_valid++;
    if (data_valid && !prev_valid && first_valid < 0) first_valid = cyc;
    if (frame_err) n_frame++;
    if (overrun_err) n_over++;
    if (parity_err) n_par++;
    prev_valid = data_valid;
    prev_ready = data_ready;
    prev_data  = data_out;
  end

  task automatic clear_mon();
    got_q.delete();
    n_valid = 0; n_frame = 0; n_over = 0; n_par = 0; first_valid = -1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t_fall;

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par);
    rx = 1'b0;
    t_fall = cyc;
    step(BIT);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx = d[i];
      step(BIT);
    end
    if (PBITS != 0) begin
      rx = par;
      step(BIT);
    end
    rx = stop_bit;
    step(BIT);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_frame"}, 32'(n_frame), 32'd0);
    check({tag, "_over"}, 32'(n_over), 32'd0);
    check({tag, "_par"}, 32'(n_par), 32'd0);
  endtask

  // Reference model state for the randomized section.
  logic [7:0] exp_q[$];
  logic [7:0] rd, pend_byte;
  logic       rr, sbad, pbad, pend_valid;
  int         exp_frame, exp_over, exp_par;

  initial begin
    rst = 1'b0; rx = 1'b1; data_ready = 1'b1;
    clear_mon();
    step(4);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_errs", {29'd0, frame_err, overrun_err, parity_err}, 32'd0);
    rst = 1'b1;
    step(20);

    // Clean byte with the consumer always ready.
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b0);
    step(GAP);
    check("clean_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("clean_data", 32'(got_q[0]), 32'hA5);
    check("clean_valid_cycles", 32'(n_valid), 32'd1);
    check("clean_latency", 32'(first_valid - t_fall), 32'(LAT));
    check_quiet("clean");
    check("clean_busy", 32'(busy), 32'd0);

    // Short low glitch is rejected at the mid start-bit sample.
    clear_mon();
    rx = 1'b0;
    step(20);
    check("glitch_busy_hi", 32'(busy), 32'd1);
    step(30);
    rx = 1'b1;
    step(100);
    check("glitch_busy_lo", 32'(busy), 32'd0);
    check("glitch_valid", 32'(n_valid), 32'd0);
    check_quiet("glitch");

    // Low stop bit followed by a held break.
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0);
    step(400);
    check("break_frame_err", 32'(n_frame), 32'd1);
    check("break_valid", 32'(n_valid), 32'd0);
    check("break_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    step(10);
    check("break_recover", 32'(busy), 32'd0);
    step(GAP);

    // Overrun: consumer stalled across two frames.
    clear_mon();
    data_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    step(GAP);
    send_frame(8'h22, 1'b1, 1'b0);
    step(GAP);
    check("ovr_pulse", 32'(n_over), 32'd1);
    check("ovr_valid", 32'(data_valid), 32'd1);
    check("ovr_data", 32'(data_out), 32'h11);
    data_ready = 1'b1;
    step(5);
    check("ovr_drain_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("ovr_drain_data", 32'(got_q[0]), 32'h11);
    check("ovr_drained", 32'(data_valid), 32'd0);

    // Reset in the middle of the data bits of 0x55.
    clear_mon();
    rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(8'h55 >> i);
      step(BIT);
    end
    rx = 1'b1;
    step(BIT / 2);
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    step(3);
    check("midrst_data_out", 32'(data_out), 32'h0);
    check("midrst_valid", 32'(data_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    step(300);
    send_frame(8'h0F, 1'b1, 1'b0);
    step(GAP);
    check("midrst_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("midrst_data", 32'(got_q[0]), 32'h0F);
    check_quiet("midrst");

`ifdef UART_RX_CTRL_PARITY_EN
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1);
    step(GAP);
    check("par_ok_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("par_ok_data", 32'(got_q[0]), 32'h07);
    check_quiet("par_ok");
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0);
    step(GAP);
    check("par_bad_err", 32'(n_par), 32'd1);
    check("par_bad_valid", 32'(n_valid), 32'd0);
    clear_mon();
    send_frame(8'h07, 1'b0, 1'b0);
    rx = 1'b1;
    step(GAP);
    check("par_prec_frame", 32'(n_frame), 32'd1);
    check("par_prec_par", 32'(n_par), 32'd0);
`endif

    // Randomized frames against the frame-level outcome model.
    clear_mon();
    exp_q.delete();
    exp_frame = 0; exp_over = 0; exp_par = 0;
    pend_valid = 1'b0; pend_byte = '0;
    for (int f = 0; f < 12; f++) begin
      rd   = 8'($urandom);
      rr   = ($urandom_range(0, 3) != 0);
      sbad = ($urandom_range(0, 4) == 0);
      pbad = (PBITS != 0) && ($urandom_range(0, 3) == 0);
      data_ready = rr;
      if (rr && pend_valid) begin
        exp_q.push_back(pend_byte);
        pend_valid = 1'b0;
      end
      if (sbad)            exp_frame++;
      else if (pbad)       exp_par++;
      else if (pend_valid) exp_over++;
      else if (rr)         exp_q.push_back(rd);
      else begin
        pend_valid = 1'b1;
        pend_byte  = rd;
      end
      send_frame(rd, !sbad, (^rd) ^ pbad);
      rx = 1'b1;
      step(GAP);
      check("rnd_frame", 32'(n_frame), 32'(exp_frame));
      check("rnd_over", 32'(n_over), 32'(exp_over));
      check("rnd_par", 32'(n_par), 32'(exp_par));
      check("rnd_count", 32'(got_q.size()), 32'(exp_q.size()));
    end
    data_ready = 1'b1;
    if (pend_valid) exp_q.push_back(pend_byte);
    step(5);
    check("rnd_final_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("rnd_data", 32'(got_q[i]), 32'(exp_q[i]));
    check("rnd_final_valid", 32'(data_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
